seq_mult_ctrl: RTL and testbench



---
 rtl/seq_mult_ctrl_pkg.sv | 22 ++
 rtl/seq_mult_step.sv | 33 +++
 rtl/seq_mult_ctrl.sv | 109 ++++++++++
 tb/tb_seq_mult_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_ctrl_pkg.sv
// Shared types and the bit-level adder cell for the iterative shift-add multiplier.
// The state encoding is fixed so that debug taps and other blocks decode it the same way.
package seq_mult_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One full-adder cell, returned as {carry_out, sum}.
    function automatic logic [1:0] full_add(
        input logic a,
        input logic b,
        input logic ci
    );
        return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
    endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One partial-product step: acc + (en ? areg : 0), with the carry kept in sum[WIDTH].
// Purely combinational, zero latency; it never stalls and applies no backpressure.
// It is a ripple of full-adder cells, so a carry-save variant can replace it without changing the FSM.
module seq_mult_step
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] areg,
    input  logic             en,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH-1:0] addend;
    logic [1:0]       fa;
    logic             carry;

    assign addend = en ? areg : '0;

    always_comb begin
        fa    = '0;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fa     = full_add(acc[i], addend[i], carry);
            sum[i] = fa[0];
            carry  = fa[1];
        end
        sum[WIDTH] = carry;
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencing controller for an iterative unsigned shift-add multiplier that reuses one adder step.
// out_valid rises exactly WIDTH clocks after the accept edge; the throughput is one product per WIDTH+2 clocks.
// The product is held in DONE until out_ready; in_ready is high only in IDLE, and flush aborts from any state.
module seq_mult_ctrl
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               flush,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] mreg;
    logic [WIDTH-1:0] mreg_nxt;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] areg_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH:0]   step_sum;

    seq_mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc  (acc),
        .areg (areg),
        .en   (mreg[0]),
        .sum  (step_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            mreg  <= '0;
            areg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            mreg  <= mreg_nxt;
            areg  <= areg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        mreg_nxt  = mreg;
        areg_nxt  = areg;
        cnt_nxt   = cnt;

        if (flush) begin
            // Abort wins over any handshake in the same cycle; a pending product is dropped.
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        areg_nxt  = in_a;
                        mreg_nxt  = in_b;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    // The {carry, sum, mreg} value shifts right by one, so sum[0] enters the top of mreg.
                    {acc_nxt, mreg_nxt} = {step_sum, mreg[WIDTH-1:1]};
                    cnt_nxt             = cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);
    assign out_p     = {acc, mreg};

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl, WIDTH=8: directed cases with literal products plus a randomized run against a cycle model.
module tb_seq_mult_ctrl;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           flush;
    logic           busy;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Behavioural model: steps_left counts the remaining clocks of work, res_valid marks a held result.
    int            steps_left = 0;
    bit            res_valid  = 1'b0;
    logic [2*W-1:0] m_p       = '0;
    int            delivered  = 0;

    seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic bit m_idle();
        return (steps_left == 0) && !res_valid;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steps_left = 0;
            res_valid  = 1'b0;
        end else if (flush) begin
            steps_left = 0;
            res_valid  = 1'b0;
        end else if (m_idle() && in_valid) begin
            m_p        = 16'(in_a) * 16'(in_b);
            steps_left = W;
        end else if (steps_left > 0) begin
            steps_left--;
            if (steps_left == 0) res_valid = 1'b1;
        end else if (res_valid && out_ready) begin
            res_valid = 1'b0;
            delivered++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_in_ready", in_ready, m_idle());
            check("cmp_busy", busy, steps_left > 0);
            check("cmp_out_valid", out_valid, res_valid);
            if (res_valid) check("cmp_out_p", out_p, m_p);
        end
    end

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Starts and ends 1 time unit after a rising edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp_p, input string nm);
        int n;
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(n);
        check({nm, "_latency"}, n, W);
        check({nm, "_p"}, out_p, exp_p);
        check({nm, "_model_p"}, m_p, exp_p);
        check({nm, "_in_ready_low"}, in_ready, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, "_in_ready_back"}, in_ready, 1'b1);
        check({nm, "_out_valid_drop"}, out_valid, 1'b0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_p", out_p, 16'h0000);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        do_op(8'd13, 8'd11, 16'h008F, "basic");
        do_op(8'd255, 8'd255, 16'hFE01, "max");
        do_op(8'd0, 8'hA5, 16'h0000, "zero");
        do_op(8'h80, 8'h02, 16'h0100, "pow2");

        // Backpressure: hold the result for 5 cycles while the source pulses an operand pair.
        in_a = 8'h3C; in_b = 8'h11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(n);
        check("bp_latency", n, W);
        for (int i = 0; i < 5; i++) begin
            in_a = 8'd3; in_b = 8'd3; in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            check("bp_hold_p", out_p, 16'h03FC);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        check("bp_no_extra_run", busy, 1'b0);

        // Flush four steps into 7*9.
        in_a = 8'd7; in_b = 8'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("flush_busy_before", busy, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_busy", busy, 1'b0);
        check("flush_out_valid", out_valid, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        check("flush_no_result", out_valid, 1'b0);
        do_op(8'd6, 8'd7, 16'h002A, "after_flush");

        // Asynchronous reset between edges in the middle of 200*3.
        in_a = 8'd200; in_b = 8'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_p", out_p, 16'h0000);
        check("arst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(8'd200, 8'd3, 16'h0258, "after_arst");

        // Randomized traffic with backpressure and occasional flush, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (W + 4) begin @(posedge clk); #1; end
        check("final_idle", in_ready, 1'b1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
